// File: rtl/fifo_burst_drain_if.sv
// Memory-side command and write-data channels of the FIFO burst drainer.
// Handshake: a transfer happens on a cycle where valid & ready are both high; once raised,
// valid and its payload stay stable until accepted, except on a read-side FIFO reset abort.
interface fifo_burst_drain_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int COUNT_WIDTH = 10,
  parameter int ADDR_WIDTH  = 32
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [COUNT_WIDTH-1:0] cmd_len;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   wr_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid, wr_last,
    input  cmd_ready, wr_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid, wr_last,
    output cmd_ready, wr_ready
  );
endinterface

// File: rtl/fifo_burst_drain.sv
// Drains fixed-length bursts from a first-word-fall-through FIFO into a memory write port,
// issuing one command per burst and stepping the address through a frame of bursts.
module fifo_burst_drain #(
  parameter int                  DATA_WIDTH   = 256,
  parameter int                  COUNT_WIDTH  = 10,
  parameter int                  BURST_LEN    = 64,
  parameter int                  ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                  FRAME_BURSTS = 1024
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_data_valid,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_rd_usedw,
  input  logic                   fifo_rd_rst_busy,
  output logic                   fifo_rdreq,
  fifo_burst_drain_if.master     mem,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   abort_err,
  output logic [1:0]             state_dbg
);

  localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [COUNT_WIDTH-1:0] BURST_CNT = COUNT_WIDTH'(BURST_LEN);
  localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic                   fs_pend_q, fs_pend_d;
  logic                   abort_q, abort_d;

  logic cmd_valid_c, wr_valid_c, wr_last_c, rdreq_c, done_c;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= BASE_ADDR;
      idx_q     <= '0;
      beat_q    <= '0;
      fs_pend_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      beat_q    <= beat_d;
      fs_pend_q <= fs_pend_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    fs_pend_d   = fs_pend_q;
    abort_d     = abort_q;
    cmd_valid_c = 1'b0;
    wr_valid_c  = 1'b0;
    wr_last_c   = 1'b0;
    rdreq_c     = 1'b0;
    done_c      = 1'b0;

    if (frame_start) abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A frame restart left pending by an aborted burst is honoured here as well.
        if (frame_start || fs_pend_q) begin
          addr_d    = BASE_ADDR;
          idx_d     = '0;
          fs_pend_d = 1'b0;
        end
        if (enable && !fifo_rd_rst_busy && (fifo_rd_usedw >= BURST_CNT)) state_d = S_CMD;
      end
      S_CMD: begin
        if (frame_start) fs_pend_d = 1'b1;
        if (fifo_rd_rst_busy) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          cmd_valid_c = 1'b1;
          if (mem.cmd_ready) begin
            state_d = S_DATA;
            beat_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (frame_start) fs_pend_d = 1'b1;
        if (fifo_rd_rst_busy) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          wr_valid_c = fifo_data_valid & ~fifo_empty;
          wr_last_c  = wr_valid_c & (beat_q == LAST_BEAT);
          rdreq_c    = wr_valid_c & mem.wr_ready;
          if (rdreq_c) begin
            beat_d = beat_q + COUNT_WIDTH'(1);
            if (wr_last_c) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        fs_pend_d = 1'b0;
        state_d   = S_IDLE;
        if (frame_start || fs_pend_q || (idx_q == LAST_IDX)) begin
          addr_d = BASE_ADDR;
          idx_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_STEP;
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.cmd_valid = cmd_valid_c;
  assign mem.cmd_addr  = addr_q;
  assign mem.cmd_len   = LAST_BEAT;
  assign mem.wr_valid  = wr_valid_c;
  assign mem.wr_last   = wr_last_c;
  assign mem.wr_data   = (state_q == S_DATA) ? fifo_rd_data : '0;
  assign fifo_rdreq    = rdreq_c;
  assign busy          = (state_q != S_IDLE);
  assign burst_done    = done_c;
  assign abort_err     = abort_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: cycle table for the basic and backpressure bursts, directed
// corner sequences, then random traffic checked against a burst/frame-level reference model.
module tb_fifo_burst_drain;
  localparam int DW = 256;
  localparam int CW = 10;
  localparam int BL = 4;
  localparam int AW = 32;
  localparam int FB = 3;
  localparam logic [AW-1:0] BASE = '0;
  localparam int STEP = BL * DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_data_valid = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [CW-1:0] fifo_rd_usedw = '0;
  logic          fifo_rd_rst_busy = 1'b0;
  logic          fifo_rdreq;
  logic          busy, burst_done, abort_err;
  logic [1:0]    state_dbg;
  logic          cmd_ready = 1'b0;
  logic          wr_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_drain_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) mem ();
  assign mem.cmd_ready = cmd_ready;
  assign mem.wr_ready  = wr_ready;

  fifo_burst_drain #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .FRAME_BURSTS(FB)
  ) dut (
    .rd_clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .fifo_rd_data(fifo_rd_data), .fifo_data_valid(fifo_data_valid), .fifo_empty(fifo_empty),
    .fifo_rd_usedw(fifo_rd_usedw), .fifo_rd_rst_busy(fifo_rd_rst_busy), .fifo_rdreq(fifo_rdreq),
    .mem(mem), .busy(busy), .burst_done(burst_done), .abort_err(abort_err), .state_dbg(state_dbg)
  );

  // Stimulus FIFO contents and the scoreboard of words expected on the write channel.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int usedw_ovr = -1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: burst index within the frame, beat within the burst, flags.
  int m_idx = 0;
  int m_beat = 0;
  int burst_cnt = 0;
  bit m_fs = 0;
  bit m_abort = 0;
  bit m_done_exp = 0;
  bit fs_idle = 0;
  bit tb_in_burst = 0;
  bit pop_now = 0;

  typedef struct {
    int push;
    bit cmd_ready;
    bit wr_ready;
    bit e_cmd_valid;
    bit e_wr_valid;
    bit e_wr_last;
    bit e_rdreq;
    bit e_done;
    bit e_busy;
  } vec_t;
  vec_t vt[23];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  function automatic logic [AW-1:0] m_addr();
    return BASE + AW'(m_idx * STEP);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drive_fifo();
    fifo_empty      = (fifo_q.size() == 0);
    fifo_data_valid = !fifo_empty;
    fifo_rd_data    = fifo_empty ? '0 : fifo_q[0];
    fifo_rd_usedw   = (usedw_ovr >= 0) ? CW'(usedw_ovr) : CW'(fifo_q.size());
  endtask

  task automatic push(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rand_word();
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    drive_fifo();
  endtask

  task automatic monitor();
    bit last_now;
    logic [DW-1:0] e;
    last_now = 0;
    chk("burst_done", burst_done, m_done_exp);
    chk("abort_err", abort_err, m_abort);
    if (fifo_rd_rst_busy) chk("rst_busy_gate", {mem.cmd_valid, mem.wr_valid, fifo_rdreq}, 0);
    if (mem.cmd_valid) begin
      chk("cmd_addr", mem.cmd_addr, m_addr());
      chk("cmd_len", mem.cmd_len, BL - 1);
    end
    if (fifo_rdreq) chk("pop_when_empty", fifo_empty, 0);
    chk("rdreq_rule", fifo_rdreq, mem.wr_valid & wr_ready);
    if (mem.wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        e = '0;
        timeout("wr_data_unexpected");
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", mem.wr_data, e);
      end
      chk("wr_last", mem.wr_last, m_beat == BL - 1);
      m_beat++;
      if (m_beat == BL) begin
        last_now = 1;
        m_beat = 0;
        burst_cnt++;
        m_idx = m_fs ? 0 : (m_idx + 1) % FB;
        m_fs = 0;
      end
    end
    m_done_exp = last_now;
    if (frame_start) begin
      m_abort = 0;
      if (fs_idle || last_now) m_idx = 0;
      else m_fs = 1;
    end
    if (fifo_rd_rst_busy && tb_in_burst) begin
      m_abort = 1;
      m_beat = 0;
    end
    pop_now = fifo_rdreq;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    frame_start = 1'b0;
    drive_fifo();
  endtask

  task automatic finish_burst();
    int start;
    int cyc;
    start = burst_cnt;
    cyc = 0;
    while (burst_cnt == start && cyc < 300) begin
      tick();
      cyc++;
    end
    if (burst_cnt == start) timeout("burst_complete");
    tick();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{4, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 1, 0, 0, 0, 0, 1};
    vt[2]  = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[3]  = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[4]  = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[5]  = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    vt[6]  = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
    vt[7]  = '{4, 0, 1, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[10] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[12] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    vt[13] = '{0, 1, 1, 1, 0, 0, 0, 0, 1};
    vt[14] = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[15] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
    vt[16] = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[17] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
    vt[18] = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    vt[19] = '{0, 1, 0, 0, 1, 1, 0, 0, 1};
    vt[20] = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
    vt[21] = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
    vt[22] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};

    // Reset state
    drive_fifo();
    #2;
    chk("rst_outputs", {mem.cmd_valid, mem.wr_valid, mem.wr_last, fifo_rdreq, busy, burst_done, abort_err}, 0);
    chk("rst_cmd_addr", mem.cmd_addr, BASE);
    chk("rst_cmd_len", mem.cmd_len, BL - 1);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b1;

    // Basic burst and backpressure burst, cycle by cycle
    for (int i = 0; i < 23; i++) begin
      push(vt[i].push);
      cmd_ready = vt[i].cmd_ready;
      wr_ready  = vt[i].wr_ready;
      #1;
      chk($sformatf("vec%0d_cmd_valid", i), mem.cmd_valid, vt[i].e_cmd_valid);
      chk($sformatf("vec%0d_wr_valid", i), mem.wr_valid, vt[i].e_wr_valid);
      chk($sformatf("vec%0d_wr_last", i), mem.wr_last, vt[i].e_wr_last);
      chk($sformatf("vec%0d_rdreq", i), fifo_rdreq, vt[i].e_rdreq);
      chk($sformatf("vec%0d_done", i), burst_done, vt[i].e_done);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      tick();
    end

    // Threshold: one word short of a burst keeps the block idle
    cmd_ready = 1'b1;
    wr_ready  = 1'b1;
    push(BL - 1);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("thr_idle", {mem.cmd_valid, busy}, 0);
      tick();
    end
    push(1);
    #1;
    chk("thr_same_cycle", mem.cmd_valid, 0);
    tick();
    #1;
    chk("thr_next_cycle", mem.cmd_valid, 1);
    finish_burst();

    // Empty stall after two beats (usedw reports a full burst early)
    usedw_ovr = BL;
    push(2);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gate", {mem.wr_valid, fifo_rdreq}, 0);
      chk("stall_busy", busy, 1);
      tick();
    end
    usedw_ovr = -1;
    push(2);
    finish_burst();

    // frame_start during the second burst of a frame
    push(BL);
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    finish_burst();
    push(BL);
    finish_burst();

    // Read-side reset mid-DATA: gated, sticky error, retried at the same address
    push(BL);
    repeat (4) tick();
    fifo_rd_rst_busy = 1'b1;
    tb_in_burst = 1;
    #1;
    chk("abort_gate", {mem.wr_valid, fifo_rdreq}, 0);
    tick();
    fifo_rd_rst_busy = 1'b0;
    tb_in_burst = 0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_sticky", abort_err, 1);
    push(2);
    finish_burst();
    frame_start = 1'b1;
    fs_idle = 1;
    tick();
    fs_idle = 0;
    tick();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      wr_ready  = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) push($urandom_range(1, 2));
      tick();
    end
    enable = 1'b0;
    cmd_ready = 1'b1;
    wr_ready = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (busy && cyc < 300) begin
        if (fifo_q.size() == 0) push(1);
        tick();
        cyc++;
      end
      if (busy) timeout("drain");
    end
    tick();
    chk("drain_beat", m_beat, 0);

    // Asynchronous reset in the middle of a burst
    enable = 1'b1;
    push(BL);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {mem.cmd_valid, mem.wr_valid, mem.wr_last, fifo_rdreq, busy, burst_done, abort_err}, 0);
    chk("arst_state", state_dbg, 0);
    chk("arst_addr", mem.cmd_addr, BASE);
    fifo_q.delete();
    exp_q.delete();
    m_idx = 0;
    m_beat = 0;
    m_fs = 0;
    m_abort = 0;
    m_done_exp = 0;
    pop_now = 0;
    drive_fifo();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(BL);
    finish_burst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Read-side consumer of the SD-controller async FIFO, in the rd_clk domain.
- Waits until the FIFO holds one full burst, then issues a memory write command (address and length).
- Streams exactly BURST_LEN words from the first-word-fall-through FIFO output to the memory write-data channel using valid/ready.
- Advances the address per burst and wraps at the frame end.

Parameters:
- DATA_WIDTH, 256, FIFO read word width and memory write-data width.
- COUNT_WIDTH, 10, width of the FIFO read-side used-word count.
- BURST_LEN, 64, words per burst; 2..2^COUNT_WIDTH-1.
- ADDR_WIDTH, 32, memory byte address width.
- BASE_ADDR, 0, first burst byte address of a frame.
- FRAME_BURSTS, 1024, bursts per frame before the address wraps to BASE_ADDR.

Ports:
- rd_clk  in  1  block clock; same clock as the FIFO read side.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; allows new bursts to start.
- frame_start  in  1  pulse; reset address and burst index to frame start.
- fifo_rd_data  in  DATA_WIDTH  FIFO dout (fwft).
- fifo_data_valid  in  1  FIFO data_valid.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_usedw  in  COUNT_WIDTH  FIFO rd_usedw.
- fifo_rd_rst_busy  in  1  FIFO read-side reset in progress.
- fifo_rdreq  out  1  FIFO rd_en (pop).
- cmd_valid  out  1  memory command valid.
- cmd_ready  in  1  memory command accept.
- cmd_addr  out  ADDR_WIDTH  burst byte address.
- cmd_len  out  COUNT_WIDTH  burst length minus 1.
- wr_data  out  DATA_WIDTH  write data.
- wr_valid  out  1  write data valid.
- wr_ready  in  1  write data accept.
- wr_last  out  1  last beat of the burst.
- busy  out  1  high in any state except IDLE.
- burst_done  out  1  one-cycle pulse per completed burst.
- abort_err  out  1  sticky error; cleared by frame_start or reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; cmd_addr=BASE_ADDR; burst index=0; beat count=0.
  - All outputs 0 except cmd_len, which is constant BURST_LEN-1.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - Go to CMD when enable=1, fifo_rd_rst_busy=0 and fifo_rd_usedw>=BURST_LEN (unsigned compare).
  - cmd_valid rises on the cycle after the condition is sampled.
- CMD:
  - cmd_valid=1; cmd_addr and cmd_len held stable until cmd_ready=1.
  - On that cycle the command is accepted; go to DATA with beat count=0.
- DATA:
  - wr_valid = fifo_data_valid & ~fifo_empty.
  - wr_data = fifo_rd_data (combinational pass-through).
  - fifo_rdreq = wr_valid & wr_ready; a beat transfers when both are high.
  - wr_last = wr_valid & (beat count == BURST_LEN-1).
  - Beat count increments on each transfer.
  - On the transfer with wr_last=1, go to DONE.
  - No pop ever occurs while empty; a stall on empty or on wr_ready=0 just holds the state.
- DONE (one cycle):
  - burst_done=1.
  - If burst index==FRAME_BURSTS-1: cmd_addr=BASE_ADDR and index=0.
  - Otherwise: cmd_addr += BURST_LEN*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH) and index+1.
  - Return to IDLE.
- enable=0 mid-burst: the current burst completes; no new burst starts.
- frame_start:
  - In IDLE it takes effect the next cycle (address=BASE_ADDR, index=0).
  - In CMD, DATA or DONE it is latched and applied in DONE; it overrides the increment/wrap.
  - It also clears abort_err.
- fifo_rd_rst_busy=1 while in CMD or DATA:
  - Drop cmd_valid, wr_valid and fifo_rdreq immediately (combinational gating).
  - Set abort_err.
  - Next state is IDLE; address and index are unchanged, so the burst is retried.
- Back-to-back bursts: minimum gap of 2 cycles between wr_last and the next cmd_valid (DONE, then IDLE).

Test Plan:
- Basic burst: BURST_LEN=4, rd_usedw=4, cmd_ready=1, wr_ready=1, FIFO holds words A0..A3.
  - Required: cmd_valid for 1 cycle with cmd_addr=0 and cmd_len=3.
  - Then 4 consecutive beats A0..A3 with wr_last on A3, 4 rdreq pulses, then burst_done.
- Threshold: rd_usedw=3 with BURST_LEN=4 and enable=1 -> stays IDLE with cmd_valid=0 for 20 cycles; raising rd_usedw to 4 -> cmd_valid the next cycle.
- Backpressure:
  - Hold cmd_ready=0 for 5 cycles -> cmd_valid and cmd_addr stay stable.
  - Toggle wr_ready 1,0,1,0 -> fifo_rdreq asserted only on ready cycles.
  - Data order preserved; exactly 4 pops.
- Empty stall: FIFO goes empty after 2 beats -> wr_valid=0 and fifo_rdreq=0; the burst resumes when refilled, with wr_last on the 4th beat.
- Address wrap: FRAME_BURSTS=3, DATA_WIDTH=256, BURST_LEN=4 -> cmd_addr sequence 0, 128, 256, 0; frame_start during the 2nd burst -> 3rd burst at address 0.
- Reset/abort:
  - fifo_rd_rst_busy pulse in DATA -> outputs gated, abort_err=1, burst retried at the same cmd_addr.
  - rst_n low mid-DATA -> all outputs 0 asynchronously and state=IDLE.
